// File: rtl/pe_pkg.sv
// Shared definitions for the process-element operand sequencer: default widths,
// the sequencer state encoding and a timer-width helper.
package pe_pkg;

  localparam int WIDTH_DATA  = 16;
  localparam int WIDTH_MDATA = 32;

  typedef enum logic [2:0] {
    S_LOAD,
    S_STREAM,
    S_FLUSH,
    S_FORMAT,
    S_WAIT,
    S_RESULT
  } seq_state_e;

  // The phase timer counts down from (cycles - 1), so the longest phase sets the width.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pe_pair_buffer.sv
// Operand-pair store: one write port, one registered read port that returns zero
// when not reading and forwards a same-cycle write to the slot being read.
module pe_pair_buffer #(
  parameter int WIDTH_DATA = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [WIDTH_DATA-1:0] wr_a,
  input  logic [WIDTH_DATA-1:0] wr_b,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [WIDTH_DATA-1:0] rd_a,
  output logic [WIDTH_DATA-1:0] rd_b
);

  logic [2*WIDTH_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_a, wr_b};
  end

  // Forwarding covers a one-pair vector, whose only pair is read on the edge it is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) {rd_a, rd_b} <= {wr_a, wr_b};
      else                               {rd_a, rd_b} <= mem[rd_addr];
    end else begin
      rd_a <= '0;
      rd_b <= '0;
    end
  end

endmodule

// File: rtl/pe_operand_sequencer.sv
// Collects a vector of operand pairs, replays them back-to-back to the process
// element, strobes its formatter and captures the formatted result for downstream.
//
// state  | meaning
// LOAD   | accept pairs into the buffer until last flag or buffer full
// STREAM | drive one buffered pair per cycle in acceptance order
// FLUSH  | drive zero operands for FLUSH_CYC cycles
// FORMAT | hold format_en_o high for FMT_CYC cycles
// WAIT   | let the PE result settle for RES_LAT cycles, then sample it
// RESULT | offer the captured result until res_ready_i
module pe_operand_sequencer #(
  parameter int WIDTH_DATA = pe_pkg::WIDTH_DATA,
  parameter int DEPTH      = 16,
  parameter int FLUSH_CYC  = 1,
  parameter int FMT_CYC    = 1,
  parameter int RES_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH_DATA-1:0] in_a_i,
  input  logic [WIDTH_DATA-1:0] in_b_i,
  input  logic                  in_last_i,
  output logic [WIDTH_DATA-1:0] data_a_o,
  output logic [WIDTH_DATA-1:0] data_b_o,
  output logic                  format_en_o,
  input  logic [WIDTH_DATA-1:0] data_pe_i,
  output logic                  res_valid_o,
  output logic [WIDTH_DATA-1:0] res_data_o,
  input  logic                  res_ready_i,
  output logic                  busy_o
);

  import pe_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int TMR_W  = tmr_width(FLUSH_CYC, FMT_CYC, RES_LAT);

  localparam logic [TMR_W-1:0] FLUSH_INIT = TMR_W'((FLUSH_CYC > 1) ? FLUSH_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] FMT_INIT   = TMR_W'((FMT_CYC > 1) ? FMT_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] RES_INIT   = TMR_W'((RES_LAT > 1) ? RES_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(DEPTH - 1);

  seq_state_e         state;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic [TMR_W-1:0]   tmr;
  logic               accept;
  logic               vec_end;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               tmr_done;

  assign accept   = (state == S_LOAD) && in_valid_i && in_ready_o;
  assign vec_end  = in_last_i || (wr_cnt == LAST_SLOT);
  assign tmr_done = (tmr == '0);
  // Slot 0 is fetched on the ending accept so the stream starts with no bubble.
  assign rd_en    = (accept && vec_end) || ((state == S_STREAM) && (rd_cnt != wr_cnt));
  assign rd_addr  = (state == S_STREAM) ? rd_cnt[ADDR_W-1:0] : '0;

  pe_pair_buffer #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_addr (wr_cnt[ADDR_W-1:0]),
    .wr_a    (in_a_i),
    .wr_b    (in_b_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_a    (data_a_o),
    .rd_b    (data_b_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      tmr         <= '0;
      in_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      format_en_o <= 1'b0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          in_ready_o <= 1'b1;
          if (accept) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (vec_end) begin
              in_ready_o <= 1'b0;
              busy_o     <= 1'b1;
              rd_cnt     <= CNT_W'(1);
              state      <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (rd_cnt == wr_cnt) begin
            if (FLUSH_CYC > 0) begin
              tmr   <= FLUSH_INIT;
              state <= S_FLUSH;
            end else begin
              tmr         <= FMT_INIT;
              format_en_o <= 1'b1;
              state       <= S_FORMAT;
            end
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        S_FLUSH: begin
          if (tmr_done) begin
            tmr         <= FMT_INIT;
            format_en_o <= 1'b1;
            state       <= S_FORMAT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_FORMAT: begin
          if (tmr_done) begin
            format_en_o <= 1'b0;
            if (RES_LAT == 0) begin
              res_data_o  <= data_pe_i;
              res_valid_o <= 1'b1;
              state       <= S_RESULT;
            end else begin
              tmr   <= RES_INIT;
              state <= S_WAIT;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_WAIT: begin
          if (tmr_done) begin
            res_data_o  <= data_pe_i;
            res_valid_o <= 1'b1;
            state       <= S_RESULT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b1;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            state       <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Bench for pe_operand_sequencer: two instances (default timing and a
// no-flush/long-format/long-latency variant) driven with identical vectors.
module tb_pe_operand_sequencer;

  localparam int W     = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last;
  logic [W-1:0]  in_a, in_b, data_pe;
  logic [1:0]    res_ready, in_ready, format_en, res_valid, busy;
  logic [W-1:0]  data_a [2];
  logic [W-1:0]  data_b [2];
  logic [W-1:0]  res_data [2];

  int checks   = 0;
  int failures = 0;

  // Per-instance phase lengths: flush, format, result latency.
  int p_f [2] = '{1, 0};
  int p_m [2] = '{1, 3};
  int p_r [2] = '{1, 2};

  logic [W-1:0] pa [$];
  logic [W-1:0] pb [$];

  typedef struct {
    int         k;
    bit         use_last;
    int         pat;
    int         dly;
    int         gap;
    logic [W-1:0] pe_base;
    int         exp_hold;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  pe_operand_sequencer #(
    .WIDTH_DATA(W), .DEPTH(DEPTH), .FLUSH_CYC(1), .FMT_CYC(1), .RES_LAT(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .data_a_o(data_a[0]), .data_b_o(data_b[0]), .format_en_o(format_en[0]),
    .data_pe_i(data_pe), .res_valid_o(res_valid[0]), .res_data_o(res_data[0]),
    .res_ready_i(res_ready[0]), .busy_o(busy[0])
  );

  pe_operand_sequencer #(
    .WIDTH_DATA(W), .DEPTH(DEPTH), .FLUSH_CYC(0), .FMT_CYC(3), .RES_LAT(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .data_a_o(data_a[1]), .data_b_o(data_b[1]), .format_en_o(format_en[1]),
    .data_pe_i(data_pe), .res_valid_o(res_valid[1]), .res_data_o(res_data[1]),
    .res_ready_i(res_ready[1]), .busy_o(busy[1])
  );

  task automatic chk1(input string name, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0b required=%0b t=%0t", name, d, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", name, d, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_one_idle(input string tag, input int d, input logic exp_rdy);
    chk1({tag, "_rdy"},   d, in_ready[d],  exp_rdy);
    chk1({tag, "_busy"},  d, busy[d],      1'b0);
    chk1({tag, "_fmt"},   d, format_en[d], 1'b0);
    chk1({tag, "_valid"}, d, res_valid[d], 1'b0);
    chkw({tag, "_a"},     d, data_a[d],    '0);
    chkw({tag, "_b"},     d, data_b[d],    '0);
  endtask

  task automatic chk_idle(input string tag, input logic exp_rdy);
    for (int d = 0; d < 2; d++) chk_one_idle(tag, d, exp_rdy);
  endtask

  task automatic gen_pairs(input int pat, input int k);
    pa.delete();
    pb.delete();
    for (int i = 0; i < k; i++) begin
      case (pat)
        0:       begin pa.push_back(16'(i + 1)); pb.push_back(16'(i + 1)); end
        1:       begin pa.push_back((i == 0) ? 16'd3 : 16'd7); pb.push_back((i == 0) ? 16'd5 : 16'd2); end
        3:       begin pa.push_back(16'd9); pb.push_back(16'd9); end
        default: begin pa.push_back(16'($urandom)); pb.push_back(16'($urandom)); end
      endcase
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready != 2'b11 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (in_ready != 2'b11) begin
      failures++;
      $display("FAIL ready_timeout actual=%0b required=11 t=%0t", in_ready, $time);
    end
  endtask

  // Drive pairs 0..k-1; returns with the ending accept just taken (sample j=0).
  task automatic load_pairs(input int k, input bit use_last, input int gap);
    wait_ready();
    for (int i = 0; i < k; i++) begin
      if (gap > 0) begin
        repeat ($urandom_range(0, gap)) begin
          in_valid = 1'b0;
          step();
          chk_idle("load_gap", 1'b1);
        end
      end
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      in_last  = (i == k - 1) ? use_last : 1'b0;
      step();
      if (i < k - 1) chk_idle("load", 1'b1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expected outputs j samples after the ending accept, from the phase lengths alone.
  task automatic check_at(input int d, input int j, input int k, input int vj, input int dly,
                          input logic [W-1:0] exp_res);
    int endj;
    endj = vj + dly;
    if (j < k) begin
      chkw("stream_a", d, data_a[d], pa[j]);
      chkw("stream_b", d, data_b[d], pb[j]);
      chk1("stream_fmt", d, format_en[d], 1'b0);
      chk1("stream_busy", d, busy[d], 1'b1);
      chk1("stream_rdy", d, in_ready[d], 1'b0);
      chk1("stream_valid", d, res_valid[d], 1'b0);
    end else if (j < vj) begin
      chkw("tail_a", d, data_a[d], '0);
      chkw("tail_b", d, data_b[d], '0);
      chk1("tail_fmt", d, format_en[d], (j >= k + p_f[d]) && (j < k + p_f[d] + p_m[d]));
      chk1("tail_busy", d, busy[d], 1'b1);
      chk1("tail_rdy", d, in_ready[d], 1'b0);
      chk1("tail_valid", d, res_valid[d], 1'b0);
    end else if (j <= endj) begin
      chk1("res_valid", d, res_valid[d], 1'b1);
      chkw("res_data", d, res_data[d], exp_res);
      chk1("res_busy", d, busy[d], 1'b1);
      chk1("res_rdy", d, in_ready[d], 1'b0);
      chk1("res_fmt", d, format_en[d], 1'b0);
    end else if (j == endj + 1) begin
      chk_one_idle("done", d, 1'b1);
    end
  endtask

  task automatic run_vec(input int k, input bit use_last, input int dly, input int gap,
                         input logic [W-1:0] pe_base, input int exp_hold);
    int vj [2];
    int hold [2];
    logic [W-1:0] exp_res [2];
    int minend, jmax;
    load_pairs(k, use_last, gap);
    for (int d = 0; d < 2; d++) begin
      vj[d]      = k + p_f[d] + p_m[d] + p_r[d];
      hold[d]    = 0;
      exp_res[d] = 16'(pe_base + 16'(vj[d] - 1));
    end
    minend = ((vj[0] < vj[1]) ? vj[0] : vj[1]) + dly;
    jmax   = ((vj[0] > vj[1]) ? vj[0] : vj[1]) + dly + 1;
    for (int j = 0; j <= jmax; j++) begin
      for (int d = 0; d < 2; d++) begin
        check_at(d, j, k, vj[d], dly, exp_res[d]);
        if (res_valid[d]) hold[d]++;
      end
      // Junk offered while both instances are busy must never be taken.
      in_valid = (j < minend) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      data_pe  = 16'(pe_base + 16'(j));
      for (int d = 0; d < 2; d++) res_ready[d] = (dly == 0) || (j >= vj[d] + dly);
      step();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    res_ready = 2'b00;
    for (int d = 0; d < 2; d++) chki("valid_hold", d, hold[d], exp_hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    data_pe   = '0;
    res_ready = 2'b00;

    tbl[0] = '{16, 1'b1, 0, 0, 0, 16'h00A0, 1};
    tbl[1] = '{2,  1'b1, 1, 4, 0, 16'h1230, 5};
    tbl[2] = '{16, 1'b0, 2, 1, 0, 16'h5500, 2};
    tbl[3] = '{1,  1'b1, 3, 0, 0, 16'hBEE0, 1};
    tbl[4] = '{5,  1'b1, 2, 2, 2, 16'hFFFE, 3};
    tbl[5] = '{16, 1'b0, 2, 0, 1, 16'h0F00, 1};

    step();
    step();
    chk_idle("reset", 1'b0);
    for (int d = 0; d < 2; d++) chkw("reset_res", d, res_data[d], '0);
    rst_n = 1'b1;
    #0;
    for (int d = 0; d < 2; d++) chk1("rel_pre_rdy", d, in_ready[d], 1'b0);
    step();
    chk_idle("rel_first", 1'b1);

    for (int t = 0; t < 6; t++) begin
      gen_pairs(tbl[t].pat, tbl[t].k);
      run_vec(tbl[t].k, tbl[t].use_last, tbl[t].dly, tbl[t].gap, tbl[t].pe_base, tbl[t].exp_hold);
    end

    // Reset mid-stream of an 8-pair vector.
    gen_pairs(2, 8);
    load_pairs(8, 1'b1, 0);
    step();
    step();
    step();
    chkw("mid_stream_a", 0, data_a[0], pa[3]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async", 1'b0);
    for (int d = 0; d < 2; d++) chkw("rst_async_res", d, res_data[d], '0);
    step();
    rst_n = 1'b1;
    #0;
    for (int d = 0; d < 2; d++) chk1("rel2_pre_rdy", d, in_ready[d], 1'b0);
    step();
    chk_idle("rel2_first", 1'b1);
    repeat (6) begin
      step();
      chk_idle("no_stale_res", 1'b1);
    end

    for (int r = 0; r < 12; r++) begin
      int  k;
      bit  ul;
      int  dly;
      k   = $urandom_range(1, DEPTH);
      ul  = (k < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 3);
      gen_pairs(2, k);
      run_vec(k, ul, dly, $urandom_range(0, 2), 16'($urandom), dly + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
